// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter sharing a true dual-port RAM between NREQ requesters.
// Grants up to two requests per cycle, blocks cross-port address hazards, routes read data back.
module ram_dp_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 6,
   parameter int unsigned DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [NREQ*DW-1:0]   rdata,
   output logic [DW-1:0]        data_a,
   output logic [DW-1:0]        data_b,
   output logic [AW-1:0]        addr_a,
   output logic [AW-1:0]        addr_b,
   output logic                 we_a,
   output logic                 we_b,
   input  logic [DW-1:0]        q_a,
   input  logic [DW-1:0]        q_b
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] ptr_q, ptr_d;
   logic          rd_a_vld_q, rd_a_vld_d;
   logic          rd_b_vld_q, rd_b_vld_d;
   logic [IW-1:0] rd_a_idx_q, rd_a_idx_d;
   logic [IW-1:0] rd_b_idx_q, rd_b_idx_d;

   logic          a_found, b_found;
   logic [IW-1:0] a_idx, b_idx, cand;

   // Modular add for index wrap; NREQ need not be a power of two.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // Scan from ptr: first requester takes port A, first non-conflicting one after it takes port B.
   always_comb begin
      a_found = 1'b0;
      a_idx   = '0;
      b_found = 1'b0;
      b_idx   = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = wrap_add(ptr_q, k);
         if (req[cand]) begin
            if (!a_found) begin
               a_found = 1'b1;
               a_idx   = cand;
            end else if (!b_found &&
                         !((req_addr[32'(cand)*AW +: AW] == req_addr[32'(a_idx)*AW +: AW]) &&
                           (req_we[cand] || req_we[a_idx]))) begin
               b_found = 1'b1;
               b_idx   = cand;
            end
         end
      end
   end

   // Grant and RAM port drive; everything forced idle while reset is held.
   always_comb begin
      gnt    = '0;
      we_a   = 1'b0;
      addr_a = '0;
      data_a = '0;
      we_b   = 1'b0;
      addr_b = '0;
      data_b = '0;
      if (!rst) begin
         if (a_found) begin
            gnt[a_idx] = 1'b1;
            we_a       = req_we[a_idx];
            addr_a     = req_addr[32'(a_idx)*AW +: AW];
            data_a     = req_wdata[32'(a_idx)*DW +: DW];
         end
         if (b_found) begin
            gnt[b_idx] = 1'b1;
            we_b       = req_we[b_idx];
            addr_b     = req_addr[32'(b_idx)*AW +: AW];
            data_b     = req_wdata[32'(b_idx)*DW +: DW];
         end
      end
   end

   // Pointer advances past the last winner; granted reads are tagged for the return cycle.
   always_comb begin
      ptr_d      = ptr_q;
      rd_a_vld_d = 1'b0;
      rd_a_idx_d = a_idx;
      rd_b_vld_d = 1'b0;
      rd_b_idx_d = b_idx;
      if (a_found) begin
         ptr_d      = wrap_add(b_found ? b_idx : a_idx, 1);
         rd_a_vld_d = !req_we[a_idx];
      end
      if (b_found) begin
         rd_b_vld_d = !req_we[b_idx];
      end
   end

   // Steer the RAM read data to the requester recorded in each port tag.
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rd_a_vld_q && (rd_a_idx_q == IW'(i))) begin
            rvalid[i]            = 1'b1;
            rdata[i*DW +: DW]    = q_a;
         end else if (rd_b_vld_q && (rd_b_idx_q == IW'(i))) begin
            rvalid[i]            = 1'b1;
            rdata[i*DW +: DW]    = q_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         rd_a_vld_q <= 1'b0;
         rd_a_idx_q <= '0;
         rd_b_vld_q <= 1'b0;
         rd_b_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rd_a_vld_q <= rd_a_vld_d;
         rd_a_idx_q <= rd_a_idx_d;
         rd_b_vld_q <= rd_b_vld_d;
         rd_b_idx_q <= rd_b_idx_d;
      end
   end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter with a behavioural dual-port RAM and a read-return scoreboard.
module tb_ram_dp_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 6;
   localparam int unsigned DW   = 8;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_we;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_wdata;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rvalid;
   logic [NREQ*DW-1:0]  rdata;
   logic [DW-1:0]       data_a, data_b;
   logic [AW-1:0]       addr_a, addr_b;
   logic                we_a, we_b;
   logic [DW-1:0]       q_a, q_b;

   ram_dp_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .data_a(data_a), .data_b(data_b), .addr_a(addr_a), .addr_b(addr_b),
      .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b)
   );

   // Behavioural true dual-port RAM with registered read.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } sb_t;

   sb_t           sb [$];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   int            vectors;
   int            miscompares;
   int            cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]               = 1'b1;
      req_we[i]            = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drop(input int i);
      req[i] = 1'b0;
   endtask

   // One arbitration cycle: check grants and due read returns, then log newly granted reads.
   task automatic step(input string tag, input logic [NREQ-1:0] exp_gnt);
      logic [NREQ-1:0] exp_rv;
      sb_t             keep [$];
      logic [AW-1:0]   a;
      @(negedge clk);
      chk({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
      exp_rv = '0;
      foreach (sb[j]) if (sb[j].due == cyc) exp_rv[sb[j].idx] = 1'b1;
      chk({tag, ":rvalid"}, 32'(rvalid), 32'(exp_rv));
      foreach (sb[j]) begin
         if (sb[j].due == cyc)
            chk($sformatf("%s:rdata%0d", tag, sb[j].idx), 32'(rdata[sb[j].idx*DW +: DW]), 32'(sb[j].data));
         else
            keep.push_back(sb[j]);
      end
      sb = keep;
      for (int i = 0; i < NREQ; i++) begin
         if (exp_gnt[i]) begin
            a = req_addr[i*AW +: AW];
            if (req_we[i]) shadow[a] = req_wdata[i*DW +: DW];
            else sb.push_back('{idx: i, data: shadow[a], due: cyc + 1});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]    = '0;
         shadow[i] = '0;
      end
      rst       = 1'b0;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      #1 rst = 1'b1;
      set_rq(0, 1'b1, 6'h01, 8'h5A);
      set_rq(1, 1'b0, 6'h02, 8'h00);
      #2;
      chk("reset:gnt",    32'(gnt),    32'h0);
      chk("reset:we",     32'({we_a, we_b}), 32'h0);
      chk("reset:addr",   32'({addr_a, addr_b}), 32'h0);
      chk("reset:data",   32'({data_a, data_b}), 32'h0);
      chk("reset:rvalid", 32'(rvalid), 32'h0);
      req = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single write then read
      set_rq(0, 1'b1, 6'h00, 8'hAA);
      #1;
      chk("wr:we_a",   32'(we_a),   32'h1);
      chk("wr:addr_a", 32'(addr_a), 32'h00);
      chk("wr:data_a", 32'(data_a), 32'hAA);
      step("wr", 4'b0001);
      drop(0);
      set_rq(1, 1'b0, 6'h00, 8'h00);
      step("rd", 4'b0010);
      drop(1);
      step("rd_ret", 4'b0000);

      // Prefill with pairs of non-conflicting writes
      set_rq(2, 1'b1, 6'h10, 8'h11);
      set_rq(3, 1'b1, 6'h11, 8'h22);
      #1;
      chk("fill:we_b",   32'(we_b),   32'h1);
      chk("fill:addr_b", 32'(addr_b), 32'h11);
      chk("fill:data_b", 32'(data_b), 32'h22);
      step("fill1", 4'b1100);
      drop(2); drop(3);
      set_rq(0, 1'b1, 6'h12, 8'h33);
      set_rq(1, 1'b1, 6'h13, 8'h44);
      step("fill2", 4'b0011);
      drop(0); drop(1);
      set_rq(2, 1'b1, 6'h3F, 8'h55);
      step("fill3", 4'b0100);
      drop(2);
      set_rq(3, 1'b0, 6'h10, 8'h00);
      step("rd3", 4'b1000);
      drop(3);

      // Parallel reads from ptr=0
      set_rq(0, 1'b0, 6'h10, 8'h00);
      set_rq(1, 1'b0, 6'h11, 8'h00);
      set_rq(2, 1'b0, 6'h12, 8'h00);
      set_rq(3, 1'b0, 6'h13, 8'h00);
      step("par1", 4'b0011);
      drop(0); drop(1);
      step("par2", 4'b1100);
      drop(2); drop(3);

      // Write-write conflict on 0x05
      set_rq(0, 1'b1, 6'h05, 8'h33);
      set_rq(1, 1'b1, 6'h05, 8'h44);
      #1;
      chk("ww:idle_b", 32'({we_b, addr_b, data_b}), 32'h0);
      step("ww1", 4'b0001);
      drop(0);
      step("ww2", 4'b0010);
      set_rq(1, 1'b0, 6'h05, 8'h00);
      step("ww_rd", 4'b0010);
      drop(1);

      // Read-after-write hazard from ptr=2
      set_rq(2, 1'b1, 6'h0A, 8'hFF);
      set_rq(3, 1'b0, 6'h0A, 8'h00);
      step("raw1", 4'b0100);
      drop(2);
      step("raw2", 4'b1000);
      drop(3);

      // Same-address reads
      set_rq(0, 1'b0, 6'h3F, 8'h00);
      set_rq(1, 1'b0, 6'h3F, 8'h00);
      step("ss1", 4'b0011);
      drop(0); drop(1);
      step("ss_ret", 4'b0000);

      // Conflicting candidate skipped, later one wins port B across the wrap
      set_rq(2, 1'b1, 6'h01, 8'h77);
      set_rq(3, 1'b0, 6'h01, 8'h00);
      set_rq(0, 1'b0, 6'h02, 8'h00);
      #1;
      chk("skip:we_b",   32'(we_b),   32'h0);
      chk("skip:addr_b", 32'(addr_b), 32'h02);
      step("skip1", 4'b0101);
      drop(2); drop(0);
      step("skip2", 4'b1000);
      drop(3);
      step("skip_ret", 4'b0000);

      // Reset while a read return is pending
      set_rq(0, 1'b0, 6'h00, 8'h00);
      step("prerst", 4'b0001);
      drop(0);
      chk("mid:rvalid_pre", 32'(rvalid), 32'h1);
      set_rq(0, 1'b0, 6'h10, 8'h00);
      set_rq(1, 1'b0, 6'h11, 8'h00);
      set_rq(2, 1'b0, 6'h12, 8'h00);
      rst = 1'b1;
      #1;
      chk("mid:rvalid", 32'(rvalid), 32'h0);
      chk("mid:gnt",    32'(gnt),    32'h0);
      chk("mid:we",     32'({we_a, we_b}), 32'h0);
      sb.delete();
      #1 rst = 1'b0;
      step("restart", 4'b0011);
      drop(0); drop(1);
      step("restart2", 4'b0100);
      drop(2);
      step("drain", 4'b0000);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_dp_arbiter.md
Name: ram_dp_arbiter

Overview:
Arbiter that shares the two ports of the true dual-port RAM (8-bit data, 64 words, single clock, registered read) among NREQ requesters.
- Each cycle it grants up to two requests, one on port A and one on port B, in round-robin order.
- It blocks same-address hazards across the two ports.
- It routes the registered read data back to the requester that issued the read.
- It sits between client logic and the RAM instance.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 6, address width
DW, 8, data width

Ports:
clk  in  1  clock shared with the RAM
rst  in  1  asynchronous, active-high reset
req  in  NREQ  request valid per requester; held with fields stable until granted
req_we  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data
gnt  out  NREQ  grant, combinational, one-hot per granted requester (at most two bits set)
rvalid  out  NREQ  read data valid, registered
rdata  out  NREQ*DW  packed read data, meaningful only when the matching rvalid bit is 1
data_a, data_b  out  DW  RAM write data
addr_a, addr_b  out  AW  RAM addresses
we_a, we_b  out  1  RAM write enables
q_a, q_b  in  DW  RAM read data (valid one cycle after the address cycle)

Behaviour:
- Reset (async assert, sync release): ptr=0; rvalid=0; pipeline tags cleared. While rst=1: gnt=0, we_a=we_b=0, addr_*=0, data_*=0.
- Scan order each cycle: ptr, ptr+1, ..., wrapping mod NREQ.
- Port A selection: the first requester with req=1 gets port A.
- Port B selection: the next requester with req=1 that does not conflict with the port A winner gets port B.
  - Conflict = same address AND at least one of the two is a write.
  - A conflicting candidate is skipped, not granted; scanning continues.
- Two reads to the same address do not conflict; both are granted.
- Granted requesters see gnt=1 in the same cycle. The RAM samples the port signals at that posedge; a requester drops or changes its request after the edge.
- Idle port: we=0, addr=0, data=0.
- Pointer update at posedge when any grant occurs: ptr = (index of the last granted requester in scan order + 1) mod NREQ. No grant: ptr unchanged.
- Read return:
  - For each granted read, register {valid, requester index, port}.
  - Next cycle: rvalid[idx]=1 for exactly one cycle, and rdata[idx] = q_a or q_b of the recorded port.
  - Latency from gnt to rvalid is exactly 1 cycle. Back-to-back reads by the same requester give rvalid on consecutive cycles.
- Writes produce no rvalid.
- Write data is visible to a read granted in any later cycle. A same-cycle write/read to the same address can never be granted together.
- Reset mid-operation clears pending rvalid immediately (async); an in-flight read is lost.
- Width rules: index fields are ceil(log2(NREQ)) bits; ptr wrap uses mod NREQ, not a power-of-two mask.

Test Plan:
- Single write then read: req0 writes 0xAA to 0x00; next cycle req1 reads 0x00 -> gnt[0] in cycle 1 on port A; gnt[1] in cycle 2; rvalid[1]=1 in cycle 3 with rdata[1]=0xAA.
- Parallel reads with all four requesting different addresses, ptr=0 -> cycle 1 gnt=0011 (req0 on A, req1 on B), ptr becomes 2; cycle 2 gnt=1100, ptr becomes 0; each rvalid arrives one cycle after its grant with the correct data.
- Write-write conflict: req0 writes 0x33 and req1 writes 0x44, both to 0x05, ptr=0 -> cycle 1 gnt=0001 only; cycle 2 gnt=0010; a later read of 0x05 returns 0x44.
- Read-after-write hazard: req2 writes 0xFF to 0x0A while req3 reads 0x0A, ptr=2 -> req2 granted alone; req3 granted the next cycle; rvalid[3] returns 0xFF (never stale data).
- Same-address reads: req0 and req1 both read 0x3F (holding 0x55) -> both granted in the same cycle; both rvalid the next cycle with 0x55.
- Reset mid-read: assert rst in the cycle after a read grant -> rvalid=0 immediately, gnt=0, we_a=we_b=0; after release ptr=0 and arbitration restarts from req0.
